// File: rtl/mips_exc_pkg.sv
// mips_exc_pkg: shared FSM states, ExcCodes, CP0 selects and handler vectors
package mips_exc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_HANDLER} state_t;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam logic [1:0] SEL_EPC = 2'd0;
  localparam logic [1:0] SEL_CAUSE = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_COUNT = 2'd3;
  localparam logic [11:0] VEC_RI = 12'h3F0;
  localparam logic [11:0] VEC_OV = 12'h3F8;
  function automatic logic [4:0] exc_code(input logic ri, input logic ov);
    return ri ? EXC_RI : ov ? EXC_OV : 5'd0;
  endfunction
endpackage

// File: rtl/mips_cp0_regs.sv
// mips_cp0_regs: EPC/Cause/Status/Count register set with MTC0 write and MFC0 read
module mips_cp0_regs
  import mips_exc_pkg::*;
#(
  parameter int WSIZE = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_take,
  input  logic             i_eret,
  input  logic [WSIZE-1:0] i_pc,
  input  logic [4:0]       i_code,
  input  logic             i_we,
  input  logic [1:0]       i_sel,
  input  logic [WSIZE-1:0] i_wdata,
  output logic [WSIZE-1:0] o_epc,
  output logic [WSIZE-1:0] o_cause,
  output logic             o_exl,
  output logic [CNT_W-1:0] o_count,
  output logic [WSIZE-1:0] o_rdata
);
  logic [WSIZE-1:0] r_epc;
  logic [4:0]       r_code;
  logic             r_exl;
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc <= '0;
      r_code <= '0;
      r_exl <= 1'b0;
      r_count <= '0;
    end else if (i_take) begin
      if (!r_exl) r_epc <= i_pc;
      r_code <= i_code;
      r_exl <= 1'b1;
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end else begin
      if (i_we && i_sel == SEL_EPC) r_epc <= i_wdata;
      if (i_eret) r_exl <= 1'b0;
      else if (i_we && i_sel == SEL_STATUS) r_exl <= i_wdata[1];
    end
  end
  assign o_epc = r_epc;
  assign o_cause = {{(WSIZE-7){1'b0}}, r_code, 2'b00};
  assign o_exl = r_exl;
  assign o_count = r_count;
  always_comb begin
    o_rdata = i_sel == SEL_EPC    ? r_epc :
              i_sel == SEL_CAUSE  ? o_cause :
              i_sel == SEL_STATUS ? {{(WSIZE-2){1'b0}}, r_exl, 1'b0} :
                                    {{(WSIZE-CNT_W){1'b0}}, r_count};
  end
endmodule

// File: rtl/mips_exception_sequencer.sv
// mips_exception_sequencer: squashes faulting instructions and sequences handler entry and ERET return
module mips_exception_sequencer
  import mips_exc_pkg::*;
#(
  parameter int WSIZE = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exception,
  input  logic [WSIZE-1:0] exception_ADDR,
  input  logic             overflow,
  input  logic             unknown_opcode,
  input  logic [WSIZE-1:0] pc,
  input  logic             eret,
  input  logic             mtc0_we,
  input  logic [1:0]       cp0_sel,
  input  logic [WSIZE-1:0] mtc0_wdata,
  output logic             flush,
  output logic             pc_redirect,
  output logic [WSIZE-1:0] redirect_ADDR,
  output logic [WSIZE-1:0] epc,
  output logic [WSIZE-1:0] cause,
  output logic             status_exl,
  output logic [WSIZE-1:0] mfc0_rdata,
  output logic [CNT_W-1:0] exc_count
);
  state_t           r_state, w_next;
  logic             r_pc_redirect;
  logic [WSIZE-1:0] r_redirect_addr;
  logic             w_eret_ok;
  logic [4:0]       w_code;
  assign flush = exception;
  assign w_eret_ok = eret && !exception && r_state == S_HANDLER;
  assign w_code = exc_code(unknown_opcode, overflow);
  assign pc_redirect = r_pc_redirect;
  assign redirect_ADDR = r_redirect_addr;
  always_comb begin
    w_next = exception ? S_REDIRECT :
             r_state == S_REDIRECT ? S_HANDLER :
             w_eret_ok ? S_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc_redirect <= 1'b0;
      r_redirect_addr <= '0;
    end else begin
      r_state <= w_next;
      r_pc_redirect <= exception || w_eret_ok;
      if (exception) r_redirect_addr <= exception_ADDR;
      else if (w_eret_ok) r_redirect_addr <= epc;
    end
  end
  mips_cp0_regs #(.WSIZE(WSIZE), .CNT_W(CNT_W)) u_cp0 (
    .clk     (clk),
    .rst     (rst),
    .i_take  (exception),
    .i_eret  (w_eret_ok),
    .i_pc    (pc),
    .i_code  (w_code),
    .i_we    (mtc0_we && !exception),
    .i_sel   (cp0_sel),
    .i_wdata (mtc0_wdata),
    .o_epc   (epc),
    .o_cause (cause),
    .o_exl   (status_exl),
    .o_count (exc_count),
    .o_rdata (mfc0_rdata)
  );
endmodule

// File: tb/tb_mips_exception_sequencer.sv
// tb_mips_exception_sequencer: directed and random checks against a behavioural CP0 model
module tb_mips_exception_sequencer;
  import mips_exc_pkg::*;
  logic        clk = 1'b0;
  logic        rst, exception, overflow, unknown_opcode, eret, mtc0_we;
  logic [31:0] exception_ADDR, pc, mtc0_wdata;
  logic [1:0]  cp0_sel;
  logic        flush, pc_redirect, status_exl;
  logic [31:0] redirect_ADDR, epc, cause, mfc0_rdata;
  logic [7:0]  exc_count;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_epc, m_raddr;
  logic [4:0]  m_code;
  logic        m_exl, m_redir, m_handler, m_valid;
  int          m_count;
  always #5 clk = ~clk;
  mips_exception_sequencer #(.WSIZE(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .exception(exception), .exception_ADDR(exception_ADDR),
    .overflow(overflow), .unknown_opcode(unknown_opcode), .pc(pc), .eret(eret),
    .mtc0_we(mtc0_we), .cp0_sel(cp0_sel), .mtc0_wdata(mtc0_wdata), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_ADDR(redirect_ADDR), .epc(epc), .cause(cause),
    .status_exl(status_exl), .mfc0_rdata(mfc0_rdata), .exc_count(exc_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic clear_in();
    exception = 0; overflow = 0; unknown_opcode = 0; eret = 0; mtc0_we = 0;
    cp0_sel = 0; mtc0_wdata = 0; exception_ADDR = 0; pc = 0;
  endtask
  task automatic model_update();
    logic eret_ok;
    if (rst) begin
      m_epc = 0; m_raddr = 0; m_code = 0; m_exl = 0; m_redir = 0; m_handler = 0; m_count = 0;
      m_valid = 1;
    end else begin
      eret_ok = eret && !exception && m_handler && !m_redir;
      if (exception) begin
        if (!m_exl) m_epc = pc;
        m_code = unknown_opcode ? 5'd10 : 5'd12;
        m_exl = 1;
        m_count = m_count < 255 ? m_count + 1 : 255;
        m_handler = 1;
        m_redir = 1;
        m_raddr = exception_ADDR;
      end else begin
        m_redir = eret_ok;
        if (eret_ok) begin
          m_raddr = m_epc;
          m_handler = 0;
          m_exl = 0;
        end
        if (mtc0_we && cp0_sel == 2'd0) m_epc = mtc0_wdata;
        if (!eret_ok && mtc0_we && cp0_sel == 2'd2) m_exl = mtc0_wdata[1];
      end
    end
  endtask
  task automatic step();
    logic [31:0] exp_rd;
    @(negedge clk);
    if (m_valid) begin
      exp_rd = cp0_sel == 2'd0 ? m_epc : cp0_sel == 2'd1 ? {25'b0, m_code, 2'b00} :
               cp0_sel == 2'd2 ? {30'b0, m_exl, 1'b0} : m_count;
      chk("flush", {31'b0, flush}, {31'b0, exception});
      chk("mfc0_rdata", mfc0_rdata, exp_rd);
    end
    model_update();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("epc", epc, m_epc);
      chk("cause", cause, {25'b0, m_code, 2'b00});
      chk("status_exl", {31'b0, status_exl}, {31'b0, m_exl});
      chk("exc_count", {24'b0, exc_count}, m_count);
      chk("pc_redirect", {31'b0, pc_redirect}, {31'b0, m_redir});
      chk("redirect_ADDR", redirect_ADDR, m_raddr);
    end
  endtask
  initial begin
    int r;
    m_valid = 0;
    rst = 1;
    clear_in();
    step(); step();
    rst = 0;
    chk("lit_rst_epc", epc, 32'h0);
    chk("lit_rst_count", {24'b0, exc_count}, 32'h0);
    chk("lit_rst_redirect", {31'b0, pc_redirect}, 32'h0);
    exception = 1; overflow = 1; exception_ADDR = {20'b0, VEC_OV}; pc = 32'h40;
    #1 chk("lit_ov_flush", {31'b0, flush}, 32'h1);
    step();
    chk("lit_ov_redirect", {31'b0, pc_redirect}, 32'h1);
    chk("lit_ov_addr", redirect_ADDR, 32'h3F8);
    chk("lit_ov_epc", epc, 32'h40);
    chk("lit_ov_cause", cause, 32'h30);
    chk("lit_ov_exl", {31'b0, status_exl}, 32'h1);
    chk("lit_ov_count", {24'b0, exc_count}, 32'h1);
    clear_in(); step();
    chk("lit_handler_noredir", {31'b0, pc_redirect}, 32'h0);
    exception = 1; unknown_opcode = 1; pc = 32'h3F4; exception_ADDR = {20'b0, VEC_RI};
    step();
    chk("lit_nest_epc", epc, 32'h40);
    chk("lit_nest_cause", cause, 32'h28);
    chk("lit_nest_addr", redirect_ADDR, 32'h3F0);
    chk("lit_nest_count", {24'b0, exc_count}, 32'h2);
    clear_in(); step();
    exception = 1; overflow = 1; unknown_opcode = 1; pc = 32'h3F4; exception_ADDR = {20'b0, VEC_RI};
    step();
    chk("lit_dual_cause", cause, 32'h28);
    chk("lit_dual_addr", redirect_ADDR, 32'h3F0);
    clear_in(); step();
    mtc0_we = 1; cp0_sel = 0; mtc0_wdata = 32'h44;
    step();
    clear_in(); eret = 1;
    step();
    chk("lit_eret_redirect", {31'b0, pc_redirect}, 32'h1);
    chk("lit_eret_addr", redirect_ADDR, 32'h44);
    chk("lit_eret_exl", {31'b0, status_exl}, 32'h0);
    clear_in(); cp0_sel = 2;
    #1 chk("lit_eret_status_rd", mfc0_rdata, 32'h0);
    step();
    chk("lit_eret_pulse_end", {31'b0, pc_redirect}, 32'h0);
    clear_in(); exception = 1; overflow = 1; pc = 32'h100; exception_ADDR = {20'b0, VEC_OV};
    step();
    clear_in(); step();
    exception = 1; overflow = 1; eret = 1; pc = 32'h104; exception_ADDR = {20'b0, VEC_OV};
    step();
    chk("lit_exc_eret_exl", {31'b0, status_exl}, 32'h1);
    chk("lit_exc_eret_epc", epc, 32'h100);
    clear_in(); step();
    eret = 1; step();
    clear_in(); step();
    exception = 1; overflow = 1; pc = 32'h200; exception_ADDR = {20'b0, VEC_OV};
    mtc0_we = 1; cp0_sel = 0; mtc0_wdata = 32'h999;
    step();
    chk("lit_mtc0_blocked", epc, 32'h200);
    clear_in(); step();
    exception = 1; overflow = 1; pc = 32'h300; exception_ADDR = {20'b0, VEC_OV};
    step();
    chk("lit_pre_rst_redirect", {31'b0, pc_redirect}, 32'h1);
    clear_in(); rst = 1;
    step();
    rst = 0;
    chk("lit_rst_mid_redirect", {31'b0, pc_redirect}, 32'h0);
    chk("lit_rst_mid_epc", epc, 32'h0);
    chk("lit_rst_mid_exl", {31'b0, status_exl}, 32'h0);
    exception = 1; overflow = 1; exception_ADDR = {20'b0, VEC_OV};
    for (int i = 0; i < 300; i++) begin
      pc = i * 4;
      step();
    end
    chk("lit_sat_count", {24'b0, exc_count}, 32'd255);
    clear_in(); cp0_sel = 3;
    #1 chk("lit_sat_rd", mfc0_rdata, 32'd255);
    step();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      exception = $urandom_range(0, 5) == 0;
      r = $urandom_range(1, 3);
      overflow = r[0];
      unknown_opcode = r[1];
      exception_ADDR = $urandom_range(0, 1) ? {20'b0, VEC_OV} : {20'b0, VEC_RI};
      pc = $urandom & 32'hFFFF_FFFC;
      eret = $urandom_range(0, 3) == 0;
      mtc0_we = $urandom_range(0, 5) == 0;
      cp0_sel = 2'($urandom_range(0, 3));
      mtc0_wdata = $urandom;
      step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
